line_double_sched: RTL
======================

Name: line_double_sched

Overview:
- Single-clock controller that sequences a 4096 x 12 simple dual-port block RAM as a ping-pong line buffer for vertical line multiplication.
- Input pixels (RGB444) of one scanline are written into one RAM half. The previously completed line is read from the other half REPEAT times.
- The read side feeds a ready/valid output stream.
- Sits between the capture/decimation stage and the horizontal scaler/TMDS path.

Parameters:
- ADDR_W, 12, RAM address width. MSB is the bank select; line capacity is LINE_MAX = 2**(ADDR_W-1) = 2048 pixels.
- DATA_W, 12, pixel width (4:4:4).
- REPEAT, 2, output passes per stored line; legal range 1..4.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input pixel strobe; no backpressure.
- in_data  in  DATA_W  input pixel.
- in_last  in  1  qualifies in_valid; marks the final pixel of a line.
- out_ready  in  1  downstream accept.
- out_valid  out  1  output pixel valid.
- out_data  out  DATA_W  output pixel.
- out_last  out  1  final pixel of each output pass.
- ram_cea  out  1  RAM write enable.
- ram_ada  out  ADDR_W  RAM write address.
- ram_din  out  DATA_W  RAM write data.
- ram_ceb  out  1  RAM read enable.
- ram_adb  out  ADDR_W  RAM read address.
- ram_oce  out  1  RAM output clock enable; tied 1.
- ram_dout  in  DATA_W  RAM read data, valid 1 cycle after ram_ceb (bypass mode).
- overflow  out  1  sticky: pixels dropped on the write side.
- underrun  out  1  sticky: a write-side line completed while the reader was still mid-line in the other bank.

Behaviour:
- Reset values:
  - All outputs 0, except ram_oce=1.
  - wbank=0, rbank=0, both bank_full flags 0, pointers 0.
  - FSM in IDLE, FIFO empty, any in-flight read discarded.
- Write side:
  - Each accepted pixel is registered onto ram_cea/ram_ada/ram_din: RAM write occurs 1 cycle after in_valid.
  - ram_ada = {wbank, wptr}; wptr increments per pixel.
  - If bank_full[wbank]=1 at the first pixel of a line, the whole line (through in_last) is dropped and overflow is set.
  - If wptr reaches LINE_MAX-1 without in_last, further pixels are dropped, overflow is set, and the line is truncated to LINE_MAX.
  - On in_valid & in_last:
    - len[wbank] = pixel count (1..LINE_MAX);
    - bank_full[wbank] set;
    - wbank toggles;
    - wptr cleared.
- Read FSM states: IDLE, STREAM, FLUSH.
  - IDLE -> STREAM when bank_full[rbank]; rptr=0, pass=0.
  - STREAM issues a read (ram_ceb=1, ram_adb={rbank,rptr}) when fifo_count + inflight < 4.
  - On issuing rptr = len-1:
    - if pass < REPEAT-1: pass++, rptr=0, stay in STREAM;
    - else: go to FLUSH.
  - FLUSH waits until the FIFO and in-flight reads are empty, then clears bank_full[rbank], toggles rbank, and goes to IDLE.
  - underrun is set if the writer completes a line while the FSM is in STREAM or FLUSH and bank_full[wbank] was already 1.
- Output FIFO:
  - 4 entries. ram_dout is pushed on the cycle after each issued read.
  - Each entry carries a last tag, set when the issued rptr == len-1.
  - out_valid = FIFO non-empty; pop on out_valid & out_ready.
  - out_data/out_last are held stable while out_valid & !out_ready.
- Latency and throughput:
  - First out_valid is 3 cycles after bank_full[rbank] rises: IDLE->STREAM, issue, push.
  - Sustained 1 pixel/cycle with out_ready held high.
- Simultaneous events:
  - A writer set and a reader clear of bank_full in the same cycle never target the same bank, because the writer only writes a bank that is not full.
  - Both flags are updated independently in the same cycle.
- Reset mid-line: the partial line is discarded and no output pulses are produced.

Optional Feature:
- Macro LINEDBL_SCANLINE_EN.
- Defined: on passes with pass != 0, each 4-bit channel of out_data is right-shifted by 1 (50% brightness scanline effect). The pass index is tagged per FIFO entry.
- Undefined: all passes output identical data; the pass tag and shifter are absent.

Test Plan:
- Line of 8 pixels 0x001..0x008 with in_last on 0x008, out_ready=1, REPEAT=2 -> RAM writes 0x000..0x007 in bank 0; output is 0x001..0x008 twice, out_last on the 8th and 16th beats; rbank=1 and bank_full[0]=0 afterwards.
- Same line with out_ready toggling 1,0,1,0 -> 16 beats, no loss or duplication, out_data stable while stalled, FIFO never exceeds 4.
- Three back-to-back 4-pixel lines with out_ready=0 -> lines 1 and 2 stored in banks 0 and 1; line 3 dropped, overflow=1; output then delivers only lines 1 and 2.
- 2050 pixels without in_last, then in_last -> overflow=1, len=2048, 4096 output beats.
- reset asserted mid-STREAM for 1 cycle -> next cycle out_valid=0, bank_full=00, overflow=0, ram_oce=1.
- With LINEDBL_SCANLINE_EN, pixel 0xFFF -> pass 0 outputs 0xFFF, pass 1 outputs 0x777.

Source files
------------

// File: rtl/line_double_sched_if.sv
// Pixel-stream and RAM-port bundle for line_double_sched.
// master = the scheduler, slave = its surroundings (source, sink, RAM).
interface line_double_sched_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 12
);
  // Input stream has no backpressure: a pixel is taken on every cycle in_valid is high.
  // Output stream: a beat transfers on a rising edge where out_valid && out_ready;
  // while out_valid && !out_ready, out_data/out_last hold and out_valid stays high.
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              ram_cea;
  logic [ADDR_W-1:0] ram_ada;
  logic [DATA_W-1:0] ram_din;
  logic              ram_ceb;
  logic [ADDR_W-1:0] ram_adb;
  logic              ram_oce;
  logic [DATA_W-1:0] ram_dout;

  modport master (
    input  in_valid, in_data, in_last, out_ready, ram_dout,
    output out_valid, out_data, out_last,
    output ram_cea, ram_ada, ram_din, ram_ceb, ram_adb, ram_oce
  );

  modport slave (
    output in_valid, in_data, in_last, out_ready, ram_dout,
    input  out_valid, out_data, out_last,
    input  ram_cea, ram_ada, ram_din, ram_ceb, ram_adb, ram_oce
  );
endinterface

// File: rtl/line_double_sched.sv
// Ping-pong line buffer scheduler: stores one scanline per RAM half and replays it REPEAT times.
// Optional LINEDBL_SCANLINE_EN halves each channel on passes after the first.
module line_double_sched #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 12,
  parameter int REPEAT = 2
) (
  input  logic                clk,
  input  logic                reset,
  line_double_sched_if.master bus,
  output logic                overflow,
  output logic                underrun,
  output logic [1:0]          dbg_state,
  output logic [1:0]          dbg_bank_full,
  output logic                dbg_rbank,
  output logic                dbg_wbank,
  output logic [2:0]          dbg_fifo_count
);
  localparam int PTR_W = ADDR_W - 1;
  localparam int LINE_MAX = 1 << PTR_W;
  localparam logic [1:0] PASS_LAST = 2'(REPEAT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, FLUSH = 2'd2} state_t;
  state_t state, state_n;

  logic              wbank, rbank, in_line, dropping, trunc;
  logic [PTR_W-1:0]  wptr, rptr;
  logic [1:0]        bank_full, pass;
  logic [ADDR_W-1:0] len [2];

  logic first_px, drop_line, accept, commit;
  logic issue, clr_full, at_end;

  logic              inflight, inflight_last;
  logic [DATA_W-1:0] fifo_data [4];
  logic              fifo_last [4];
  logic [1:0]        wr_idx, rd_idx;
  logic [2:0]        count;
  logic              push, pop;
`ifdef LINEDBL_SCANLINE_EN
  logic [1:0]        inflight_pass;
  logic [1:0]        fifo_pass [4];
`endif

  // Write side: a line whose first pixel finds its bank still full is discarded whole.
  always_comb begin
    first_px  = bus.in_valid && !in_line;
    drop_line = dropping || (first_px && bank_full[wbank]);
    accept    = bus.in_valid && !drop_line && !trunc;
    commit    = bus.in_valid && bus.in_last && !drop_line;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.ram_cea <= 1'b0;
      bus.ram_ada <= '0;
      bus.ram_din <= '0;
      overflow    <= 1'b0;
      underrun    <= 1'b0;
      wbank       <= 1'b0;
      wptr        <= '0;
      in_line     <= 1'b0;
      dropping    <= 1'b0;
      trunc       <= 1'b0;
      len[0]      <= '0;
      len[1]      <= '0;
    end else begin
      bus.ram_cea <= accept;
      if (accept) begin
        bus.ram_ada <= {wbank, wptr};
        bus.ram_din <= bus.in_data;
      end
      if (bus.in_valid && (drop_line || trunc)) overflow <= 1'b1;
      if (bus.in_valid && bus.in_last && (state != IDLE) && bank_full[wbank]) underrun <= 1'b1;
      if (bus.in_valid) begin
        if (bus.in_last) begin
          in_line  <= 1'b0;
          dropping <= 1'b0;
          trunc    <= 1'b0;
          wptr     <= '0;
          if (commit) begin
            len[wbank] <= trunc ? ADDR_W'(LINE_MAX) : {1'b0, wptr} + ADDR_W'(1);
            wbank      <= ~wbank;
          end
        end else begin
          in_line <= 1'b1;
          if (drop_line) dropping <= 1'b1;
          else if (!trunc) begin
            // The pixel at the last slot is kept; anything after it is dropped.
            if (wptr == '1) trunc <= 1'b1;
            else wptr <= wptr + PTR_W'(1);
          end
        end
      end
    end
  end

  // Writer only ever sets a bank that is empty, reader only clears the bank it owns.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_full <= 2'b00;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (commit && (wbank == 1'(b))) bank_full[b] <= 1'b1;
        else if (clr_full && (rbank == 1'(b))) bank_full[b] <= 1'b0;
      end
    end
  end

  always_comb begin
    state_n  = state;
    issue    = 1'b0;
    clr_full = 1'b0;
    at_end   = ({1'b0, rptr} == (len[rbank] - ADDR_W'(1)));
    case (state)
      IDLE: if (bank_full[rbank]) state_n = STREAM;
      STREAM: begin
        // Reads in flight are counted so the FIFO can never be overrun.
        issue = (count + {2'b00, inflight}) < 3'd4;
        if (issue && at_end && (pass == PASS_LAST)) state_n = FLUSH;
      end
      FLUSH: begin
        if ((count == 3'd0) && !inflight) begin
          clr_full = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      rbank         <= 1'b0;
      rptr          <= '0;
      pass          <= 2'd0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
`ifdef LINEDBL_SCANLINE_EN
      inflight_pass <= 2'd0;
`endif
    end else begin
      state <= state_n;
      if ((state == IDLE) && (state_n == STREAM)) begin
        rptr <= '0;
        pass <= 2'd0;
      end else if (issue) begin
        if (at_end) begin
          rptr <= '0;
          if (pass != PASS_LAST) pass <= pass + 2'd1;
        end else begin
          rptr <= rptr + PTR_W'(1);
        end
      end
      if (clr_full) rbank <= ~rbank;
      inflight      <= issue;
      inflight_last <= issue && at_end;
`ifdef LINEDBL_SCANLINE_EN
      inflight_pass <= pass;
`endif
    end
  end

  assign push = inflight;
  assign pop  = (count != 3'd0) && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx <= 2'd0;
      rd_idx <= 2'd0;
      count  <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
`ifdef LINEDBL_SCANLINE_EN
        fifo_pass[i] <= 2'd0;
`endif
      end
    end else begin
      if (push) begin
        fifo_data[wr_idx] <= bus.ram_dout;
        fifo_last[wr_idx] <= inflight_last;
`ifdef LINEDBL_SCANLINE_EN
        fifo_pass[wr_idx] <= inflight_pass;
`endif
        wr_idx <= wr_idx + 2'd1;
      end
      if (pop) rd_idx <= rd_idx + 2'd1;
      count <= count + 3'(push) - 3'(pop);
    end
  end

`ifdef LINEDBL_SCANLINE_EN
  function automatic logic [DATA_W-1:0] dim(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = d >> 1;
    for (int c = 0; c < DATA_W / 4; c++) r[4*c+3] = 1'b0;
    return r;
  endfunction

  assign bus.out_data = (fifo_pass[rd_idx] != 2'd0) ? dim(fifo_data[rd_idx]) : fifo_data[rd_idx];
`else
  assign bus.out_data = fifo_data[rd_idx];
`endif

  assign bus.out_valid = (count != 3'd0);
  assign bus.out_last  = fifo_last[rd_idx];
  assign bus.ram_ceb   = issue;
  assign bus.ram_adb   = {rbank, rptr};
  assign bus.ram_oce   = 1'b1;

  assign dbg_state      = state;
  assign dbg_bank_full  = bank_full;
  assign dbg_rbank      = rbank;
  assign dbg_wbank      = wbank;
  assign dbg_fifo_count = count;
endmodule
